// File: rtl/aes_sched_pkg.sv
// Shared types and sizing for the AES S-box scheduler and its tag pipeline.
package aes_sched_pkg;

    localparam int unsigned NB_DATA = 16;
    localparam int unsigned NB_KEY  = 4;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned DATA_W  = NB_DATA * BYTE_W;
    localparam int unsigned KEY_W   = NB_KEY * BYTE_W;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    typedef enum logic {REQ_DATA, REQ_KEY} req_t;

    // Travels alongside each byte through the S-box latency.
    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } tag_t;

    function automatic logic [IDX_W-1:0] last_idx(input req_t req);
        return (req == REQ_DATA) ? IDX_W'(NB_DATA - 1) : IDX_W'(NB_KEY - 1);
    endfunction

endpackage

// File: rtl/sbox_tag_pipe.sv
// LAT-deep shift register of {vld, idx} tags matching the shared S-box latency.
// LAT = 0 degenerates to a wire for a combinational S-box.
module sbox_tag_pipe
    import aes_sched_pkg::*;
#(
    parameter int unsigned LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic pending_c
);

    generate
        if (LAT == 0) begin : g_pass
            assign tag_out   = tag_in;
            assign pending_c = 1'b0;
        end else begin : g_pipe
            tag_t stage_q [LAT];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < int'(LAT); i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= tag_in;
                    for (int i = 1; i < int'(LAT); i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign tag_out = stage_q[LAT-1];

            // Tags that will still be in flight after this cycle's capture.
            always_comb begin
                pending_c = 1'b0;
                for (int i = 0; i < int'(LAT) - 1; i++) begin
                    pending_c = pending_c | stage_q[i].vld;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sbox_scheduler.sv
// Arbitrates one shared S-box between SubBytes (16 B) and SubWord (4 B), one byte per cycle.
// Optional SBOX_SCHED_INV_EN adds d_inv / sbox_inv for inverse-S-box data requests.
module sbox_scheduler
    import aes_sched_pkg::*;
#(
    parameter int unsigned SBOX_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic [DATA_W-1:0] d_state,
    output logic              d_done,
    output logic [DATA_W-1:0] d_result,
    input  logic              k_valid,
    output logic              k_ready,
    input  logic [KEY_W-1:0]  k_word,
    output logic              k_done,
    output logic [KEY_W-1:0]  k_result,
    output logic [BYTE_W-1:0] sbox_in,
    output logic              sbox_vld,
    input  logic [BYTE_W-1:0] sbox_out,
`ifdef SBOX_SCHED_INV_EN
    input  logic              d_inv,
    output logic              sbox_inv,
`endif
    output logic              busy
);

    state_t            state_q, state_d;
    req_t              req_q, req_d;
    req_t              last_grant_q, last_grant_d;
    logic [DATA_W-1:0] operand_q, operand_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [IDX_W-1:0]  issue_idx_q, issue_idx_d;
    logic              issue_vld_d;
    logic [BYTE_W-1:0] issue_byte_d;
    logic              d_grant_c, k_grant_c;
    tag_t              tag_in, tag_out;
    logic              pending_c;
`ifdef SBOX_SCHED_INV_EN
    logic              inv_q, inv_d;
`endif

    // Round-robin on ties: the requester not served last wins.
    always_comb begin
        d_grant_c = d_valid & (~k_valid | (last_grant_q == REQ_KEY));
        k_grant_c = k_valid & ~d_grant_c;
        d_ready   = (state_q == IDLE) & d_grant_c & ~rst;
        k_ready   = (state_q == IDLE) & k_grant_c & ~rst;
    end

    assign tag_in = '{vld: sbox_vld, idx: issue_idx_q};

    sbox_tag_pipe #(.LAT(SBOX_LAT)) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .tag_in    (tag_in),
        .tag_out   (tag_out),
        .pending_c (pending_c)
    );

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        last_grant_d = last_grant_q;
        operand_d    = operand_q;
        issue_vld_d  = 1'b0;
        issue_idx_d  = '0;
        issue_byte_d = '0;
        shadow_d     = shadow_q;
`ifdef SBOX_SCHED_INV_EN
        inv_d        = inv_q;
`endif
        if (tag_out.vld) begin
            shadow_d[32'(tag_out.idx) * BYTE_W +: BYTE_W] = sbox_out;
        end

        case (state_q)
            IDLE: begin
                if (d_ready | k_ready) begin
                    req_d        = d_ready ? REQ_DATA : REQ_KEY;
                    last_grant_d = req_d;
                    operand_d    = d_ready ? d_state : DATA_W'(k_word);
`ifdef SBOX_SCHED_INV_EN
                    inv_d        = d_ready & d_inv;
`endif
                    issue_vld_d  = 1'b1;
                    issue_byte_d = operand_d[BYTE_W-1:0];
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_idx_q == last_idx(req_q)) begin
                    state_d = (SBOX_LAT == 0) ? DONE : DRAIN;
                end else begin
                    issue_vld_d  = 1'b1;
                    issue_idx_d  = issue_idx_q + IDX_W'(1);
                    issue_byte_d = operand_q[32'(issue_idx_d) * BYTE_W +: BYTE_W];
                end
            end
            DRAIN: begin
                if (!pending_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs; the shadow merge is forwarded into the result on DONE entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q        <= REQ_DATA;
            last_grant_q <= REQ_KEY;
            operand_q    <= '0;
            shadow_q     <= '0;
            issue_idx_q  <= '0;
            sbox_vld     <= 1'b0;
            sbox_in      <= '0;
            d_done       <= 1'b0;
            k_done       <= 1'b0;
            d_result     <= '0;
            k_result     <= '0;
            busy         <= 1'b0;
`ifdef SBOX_SCHED_INV_EN
            inv_q        <= 1'b0;
            sbox_inv     <= 1'b0;
`endif
        end else begin
            req_q        <= req_d;
            last_grant_q <= last_grant_d;
            operand_q    <= operand_d;
            shadow_q     <= shadow_d;
            issue_idx_q  <= issue_idx_d;
            sbox_vld     <= issue_vld_d;
            sbox_in      <= issue_byte_d;
            busy         <= (state_d != IDLE);
            d_done       <= 1'b0;
            k_done       <= 1'b0;
`ifdef SBOX_SCHED_INV_EN
            inv_q        <= inv_d;
            sbox_inv     <= issue_vld_d & inv_d;
`endif
            if (state_d == DONE) begin
                if (req_q == REQ_DATA) begin
                    d_done   <= 1'b1;
                    d_result <= shadow_d;
                end else begin
                    k_done   <= 1'b1;
                    k_result <= shadow_d[KEY_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_sbox_scheduler.sv
// Self-checking bench for sbox_scheduler; models the shared S-box from GF(2^8) arithmetic.
// Define SBOX_SCHED_INV_EN to also exercise the inverse-S-box path.
module tb_sbox_scheduler;

    parameter int unsigned SBOX_LAT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         d_valid, d_ready, d_done;
    logic [127:0] d_state, d_result;
    logic         k_valid, k_ready, k_done;
    logic [31:0]  k_word, k_result;
    logic [7:0]   sbox_in, sbox_out;
    logic         sbox_vld, busy;
    logic         sbox_inv_w;
`ifdef SBOX_SCHED_INV_EN
    logic         d_inv, sbox_inv;
    assign sbox_inv_w = sbox_inv;
`else
    assign sbox_inv_w = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [127:0] d_exp;
    logic [31:0]  k_exp;
    logic [7:0]   sb_t  [256];
    logic [7:0]   isb_t [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sbox_scheduler #(.SBOX_LAT(SBOX_LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .d_state  (d_state),
        .d_done   (d_done),
        .d_result (d_result),
        .k_valid  (k_valid),
        .k_ready  (k_ready),
        .k_word   (k_word),
        .k_done   (k_done),
        .k_result (k_result),
        .sbox_in  (sbox_in),
        .sbox_vld (sbox_vld),
        .sbox_out (sbox_out),
`ifdef SBOX_SCHED_INV_EN
        .d_inv    (d_inv),
        .sbox_inv (sbox_inv),
`endif
        .busy     (busy)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            y = y >> 1;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
        return (v << s) | (v >> (8 - s));
    endfunction

    task automatic build_tables();
        logic [7:0] inv, a, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            a = 8'(x);
            for (int y = 1; y < 256; y++) begin
                b = 8'(y);
                if (x != 0 && gmul(a, b) == 8'h01) inv = b;
            end
            sb_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isb_t[sb_t[x]] = 8'(x);
    endtask

    function automatic logic [7:0] sbox_ref(input logic [7:0] x, input logic inv);
        return inv ? isb_t[x] : sb_t[x];
    endfunction

    function automatic logic [127:0] expect_sub(input logic [127:0] op, input int n, input logic inv);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = sbox_ref(op[8*i +: 8], inv);
        return r;
    endfunction

    // Shared S-box model with the configured latency.
    generate
        if (SBOX_LAT == 0) begin : g_comb
            assign sbox_out = sbox_ref(sbox_in, sbox_inv_w);
        end else begin : g_pipe
            logic [7:0] pipe [SBOX_LAT];
            always @(posedge clk) begin
                pipe[0] <= sbox_ref(sbox_in, sbox_inv_w);
                for (int i = 1; i < int'(SBOX_LAT); i++) pipe[i] <= pipe[i-1];
            end
            assign sbox_out = pipe[SBOX_LAT-1];
        end
    endgenerate

    task automatic do_reset();
        rst = 1'b1; d_valid = 1'b0; k_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        d_exp = '0; k_exp = '0;
    endtask

    // Drives one request and records what the DUT did; comparisons live in the test tasks.
    task automatic do_txn(input bit key, input logic [127:0] op, input logic inv,
                          output int t0, output int t_done, output int vld_cnt, output int done_cnt,
                          output int other_done, output int inv_cnt, output int inv_bad,
                          output int busy_cnt, output logic [127:0] res, output bit timeout);
        bit got;
        t0 = -1; t_done = -1; vld_cnt = 0; done_cnt = 0; other_done = 0;
        inv_cnt = 0; inv_bad = 0; busy_cnt = 0; res = '0; timeout = 1'b0; got = 1'b0;
        if (key) begin k_valid = 1'b1; k_word = op[31:0]; end
        else begin d_valid = 1'b1; d_state = op; end
`ifdef SBOX_SCHED_INV_EN
        d_inv = inv;
`endif
        #1;
        for (int n = 0; n < 50 && !got; n++) begin
            if (key ? k_ready : d_ready) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!got) begin
            timeout = 1'b1; d_valid = 1'b0; k_valid = 1'b0;
            return;
        end
        t0 = cyc;
        @(posedge clk); #1;
        d_valid = 1'b0; k_valid = 1'b0;
`ifdef SBOX_SCHED_INV_EN
        d_inv = 1'b0;
`endif
        for (int c = 0; c < 40; c++) begin
            vld_cnt  += int'(sbox_vld);
            busy_cnt += int'(busy);
            inv_cnt  += int'(sbox_inv_w & sbox_vld);
            inv_bad  += int'(sbox_inv_w & ~sbox_vld);
            if (key ? k_done : d_done) begin
                done_cnt++;
                if (t_done < 0) begin
                    t_done = cyc;
                    res = key ? {96'b0, k_result} : d_result;
                end
            end
            if (key ? d_done : k_done) other_done++;
            @(posedge clk); #1;
        end
        if (t_done < 0) timeout = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        d_valid = 1'b1; k_valid = 1'b1; d_state = '1; k_word = '1;
        #1;
        checks++;
        if ({d_ready, k_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b expected 00", {d_ready, k_ready});
        end
        checks++;
        if ({d_done, k_done, sbox_vld, busy, sbox_in, d_result, k_result} !== '0) begin
            errors++; $display("FAIL reset_outputs: got d_res=%h k_res=%h vld=%b busy=%b in=%h expected all 0",
                               d_result, k_result, sbox_vld, busy, sbox_in);
        end
        d_valid = 1'b0; k_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy, d_ready, k_ready} !== 3'b000) begin
            errors++; $display("FAIL reset_idle: got %b expected 000", {busy, d_ready, k_ready});
        end
        d_exp = '0; k_exp = '0;
    endtask

    task automatic test_data_zero();
        int t0, td, vc, dc, od, ic, ib, bc; logic [127:0] res; bit to;
        do_txn(1'b0, '0, 1'b0, t0, td, vc, dc, od, ic, ib, bc, res, to);
        d_exp = {16{8'h63}};
        checks++;
        if (to || td !== t0 + 17 + int'(SBOX_LAT)) begin
            errors++; $display("FAIL zero_latency: got done at T0+%0d (timeout=%0d) expected T0+%0d", td - t0, to, 17 + SBOX_LAT);
        end
        checks++;
        if (vc !== 16 || bc !== 17 + int'(SBOX_LAT)) begin
            errors++; $display("FAIL zero_vld_busy: got vld=%0d busy=%0d expected 16 %0d", vc, bc, 17 + SBOX_LAT);
        end
        checks++;
        if (dc !== 1 || od !== 0) begin
            errors++; $display("FAIL zero_pulses: got d_done=%0d k_done=%0d expected 1 0", dc, od);
        end
        checks++;
        if (res !== d_exp) begin
            errors++; $display("FAIL zero_result: got %h expected %h", res, d_exp);
        end
    endtask

    task automatic test_key_known();
        int t0, td, vc, dc, od, ic, ib, bc; logic [127:0] res; bit to;
        do_txn(1'b1, 128'h00010253, 1'b0, t0, td, vc, dc, od, ic, ib, bc, res, to);
        k_exp = 32'h637C77ED;
        checks++;
        if (to || td !== t0 + 5 + int'(SBOX_LAT)) begin
            errors++; $display("FAIL key_latency: got done at T0+%0d (timeout=%0d) expected T0+%0d", td - t0, to, 5 + SBOX_LAT);
        end
        checks++;
        if (vc !== 4 || dc !== 1 || od !== 0) begin
            errors++; $display("FAIL key_counts: got vld=%0d k_done=%0d d_done=%0d expected 4 1 0", vc, dc, od);
        end
        checks++;
        if (res[31:0] !== k_exp) begin
            errors++; $display("FAIL key_result: got %h expected %h", res[31:0], k_exp);
        end
        checks++;
        if (d_result !== d_exp) begin
            errors++; $display("FAIL key_data_untouched: got %h expected %h", d_result, d_exp);
        end
    endtask

    task automatic test_ramp();
        int t0, td, vc, dc, od, ic, ib, bc; logic [127:0] res, op; bit to;
        for (int i = 0; i < 16; i++) op[8*i +: 8] = 8'(i);
        do_txn(1'b0, op, 1'b0, t0, td, vc, dc, od, ic, ib, bc, res, to);
        d_exp = expect_sub(op, 16, 1'b0);
        checks++;
        if (to || td !== t0 + 17 + int'(SBOX_LAT)) begin
            errors++; $display("FAIL ramp_latency: got done at T0+%0d expected T0+%0d", td - t0, 17 + SBOX_LAT);
        end
        checks++;
        if (res[15:8] !== 8'h7C) begin
            errors++; $display("FAIL ramp_byte1: got %h expected 7c", res[15:8]);
        end
        checks++;
        if (res !== d_exp || k_result !== k_exp) begin
            errors++; $display("FAIL ramp_result: got %h k=%h expected %h k=%h", res, k_result, d_exp, k_exp);
        end
    endtask

    task automatic test_random();
        int t0, td, vc, dc, od, ic, ib, bc, n; logic [127:0] res, op; bit to, key;
        for (int it = 0; it < 8; it++) begin
            key = 1'($urandom_range(0, 1));
            op  = {$urandom, $urandom, $urandom, $urandom};
            n   = key ? 4 : 16;
            do_txn(key, op, 1'b0, t0, td, vc, dc, od, ic, ib, bc, res, to);
            if (key) k_exp = expect_sub(op, 4, 1'b0); else d_exp = expect_sub(op, 16, 1'b0);
            checks++;
            if (to || td !== t0 + n + 1 + int'(SBOX_LAT) || vc !== n || dc !== 1 || od !== 0) begin
                errors++; $display("FAIL rand_timing[%0d]: got lat=%0d vld=%0d done=%0d other=%0d expected %0d %0d 1 0",
                                   it, td - t0, vc, dc, od, n + 1 + SBOX_LAT, n);
            end
            checks++;
            if (d_result !== d_exp || k_result !== k_exp) begin
                errors++; $display("FAIL rand_result[%0d]: got d=%h k=%h expected d=%h k=%h", it, d_result, k_result, d_exp, k_exp);
            end
        end
    endtask

    task automatic test_arbitration();
        int gq[$], aq[$], dq[$]; int both; logic [127:0] rd; logic [31:0] rk; bit exp_key;
        do_reset();
        rd = {$urandom, $urandom, $urandom, $urandom};
        rk = $urandom;
        both = 0;
        d_state = rd; k_word = rk; d_valid = 1'b1; k_valid = 1'b1;
        #1;
        for (int c = 0; c < 200 && dq.size() < 4; c++) begin
            if (d_ready && k_ready) both++;
            if (d_ready) begin gq.push_back(0); aq.push_back(cyc); end
            if (k_ready) begin gq.push_back(1); aq.push_back(cyc); end
            if (d_done) begin
                dq.push_back(cyc);
                checks++;
                if (d_result !== expect_sub(rd, 16, 1'b0)) begin
                    errors++; $display("FAIL arb_d_result: got %h expected %h", d_result, expect_sub(rd, 16, 1'b0));
                end
            end
            if (k_done) begin
                dq.push_back(cyc);
                checks++;
                if ({96'b0, k_result} !== expect_sub({96'b0, rk}, 4, 1'b0)) begin
                    errors++; $display("FAIL arb_k_result: got %h expected %h", k_result, expect_sub({96'b0, rk}, 4, 1'b0));
                end
            end
            @(posedge clk); #1;
            if (gq.size() >= 4) begin d_valid = 1'b0; k_valid = 1'b0; end
            #1;
        end
        d_valid = 1'b0; k_valid = 1'b0;
        checks++;
        if (gq.size() !== 4 || dq.size() !== 4 || both !== 0) begin
            errors++; $display("FAIL arb_counts: got grants=%0d dones=%0d both_ready=%0d expected 4 4 0", gq.size(), dq.size(), both);
        end
        exp_key = 1'b0;
        for (int j = 0; j < 4 && j < gq.size(); j++) begin
            checks++;
            if (gq[j] !== int'(exp_key)) begin
                errors++; $display("FAIL arb_order[%0d]: got %0d expected %0d (0=data 1=key)", j, gq[j], exp_key);
            end
            if (j > 0 && j - 1 < dq.size()) begin
                checks++;
                if (aq[j] !== dq[j-1] + 1) begin
                    errors++; $display("FAIL arb_next_accept[%0d]: got cycle %0d expected %0d", j, aq[j], dq[j-1] + 1);
                end
            end
            exp_key = ~exp_key;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int t0, td, vc, dc, od, ic, ib, bc, stray; logic [127:0] res, op; bit to;
        op = {$urandom, $urandom, $urandom, $urandom};
        d_state = op; d_valid = 1'b1;
        #1;
        checks++;
        if (d_ready !== 1'b1) begin
            errors++; $display("FAIL mid_ready: got %b expected 1", d_ready);
        end
        @(posedge clk); #1 d_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if ({sbox_vld, sbox_in} !== {1'b1, op[63:56]}) begin
            errors++; $display("FAIL mid_byte7: got vld=%b in=%h expected 1 %h", sbox_vld, sbox_in, op[63:56]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({d_done, k_done, sbox_vld, busy, sbox_in, d_result, k_result} !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: got d_res=%h k_res=%h vld=%b busy=%b expected all 0",
                               d_result, k_result, sbox_vld, busy);
        end
        @(posedge clk); #1 rst = 1'b0;
        d_exp = '0; k_exp = '0;
        stray = 0;
        for (int c = 0; c < 30; c++) begin
            stray += int'(d_done | k_done | busy);
            @(posedge clk); #1;
        end
        checks++;
        if (stray !== 0) begin
            errors++; $display("FAIL mid_no_done: got %0d active cycles expected 0", stray);
        end
        op = {$urandom, $urandom, $urandom, $urandom};
        do_txn(1'b0, op, 1'b0, t0, td, vc, dc, od, ic, ib, bc, res, to);
        d_exp = expect_sub(op, 16, 1'b0);
        checks++;
        if (to || res !== d_exp || td !== t0 + 17 + int'(SBOX_LAT)) begin
            errors++; $display("FAIL mid_recover: got %h lat=%0d expected %h lat=%0d", res, td - t0, d_exp, 17 + SBOX_LAT);
        end
    endtask

`ifdef SBOX_SCHED_INV_EN
    task automatic test_inv();
        int t0, td, vc, dc, od, ic, ib, bc; logic [127:0] res, op; bit to;
        do_txn(1'b0, {16{8'h63}}, 1'b1, t0, td, vc, dc, od, ic, ib, bc, res, to);
        checks++;
        if (to || res !== '0) begin
            errors++; $display("FAIL inv_result: got %h expected 0", res);
        end
        checks++;
        if (ic !== 16 || ib !== 0) begin
            errors++; $display("FAIL inv_window: got inv_issue=%0d inv_outside=%0d expected 16 0", ic, ib);
        end
        op = {96'b0, $urandom};
        do_txn(1'b1, op, 1'b1, t0, td, vc, dc, od, ic, ib, bc, res, to);
        checks++;
        if (to || ic !== 0 || ib !== 0 || res[31:0] !== expect_sub(op, 4, 1'b0)) begin
            errors++; $display("FAIL inv_key_forward: got inv=%0d/%0d res=%h expected 0/0 %h", ic, ib, res[31:0], expect_sub(op, 4, 1'b0));
        end
    endtask
`endif

    initial begin
        build_tables();
        rst = 1'b1; d_valid = 1'b0; k_valid = 1'b0; d_state = '0; k_word = '0;
`ifdef SBOX_SCHED_INV_EN
        d_inv = 1'b0;
`endif
        test_reset();
        test_data_zero();
        test_key_known();
        test_ramp();
        test_random();
        test_arbitration();
        test_reset_mid();
`ifdef SBOX_SCHED_INV_EN
        test_inv();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
